// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes and fetch FSM state for the CPU front end
package cpu_pkg;
    localparam int PC_W = 8;
    localparam int INSTR_W = 16;
    localparam logic [3:0] OP_R_LOGIC = 4'b0000;
    localparam logic [3:0] OP_R_UNARY = 4'b0001;
    localparam logic [3:0] OP_JUMP    = 4'b0011;
    localparam logic [3:0] OP_BEQ     = 4'b0100;
    localparam logic [3:0] OP_LOAD    = 4'b0111;
    localparam logic [3:0] OP_STORE   = 4'b1000;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory and decode-side handshakes of the fetch unit
interface instr_fetch_if #(
    parameter int PC_W = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               pc_src;
    logic [PC_W-1:0]    pc_target;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic [3:0]         op;
    logic [3:0]         func3;
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, op, func3,
        input  imem_gnt, imem_rvalid, imem_rdata, pc_src, pc_target, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, op, func3,
        output imem_gnt, imem_rvalid, imem_rdata, pc_src, pc_target, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry instruction/PC buffer with flush
module fetch_fifo #(
    parameter int PC_W = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] push_data,
    input  logic [PC_W-1:0]    push_pc,
    output logic [INSTR_W-1:0] head_data,
    output logic [PC_W-1:0]    head_pc,
    output logic [1:0]         count,
    output logic               full,
    output logic               empty
);
    logic [INSTR_W-1:0] data [2];
    logic [PC_W-1:0]    pcs [2];
    logic               rd_ptr, wr_ptr;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '{default: '0};
            pcs <= '{default: '0};
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                data[wr_ptr] <= push_data;
                pcs[wr_ptr] <= push_pc;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
    assign head_data = data[rd_ptr];
    assign head_pc = pcs[rd_ptr];
    assign full = count == 2'd2;
    assign empty = count == 2'd0;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit feeding a 2-entry decode buffer
module instr_fetch #(
    parameter int PC_W = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);
    import cpu_pkg::*;
    fetch_state_t       state, state_n;
    logic [PC_W-1:0]    fetch_pc, issued_pc, head_pc;
    logic [INSTR_W-1:0] head_data;
    logic [1:0]         count, count_n;
    logic               drop, flush, granted, accept, push, pop, full, empty;
    assign flush = bus.pc_src;
    assign granted = state == REQ && bus.imem_gnt;
    assign accept = state == WAIT && bus.imem_rvalid;
    assign push = accept && !drop && !flush && (!full || pop);
    assign pop = !empty && bus.instr_ready && !flush;
    assign count_n = flush ? 2'd0 : count + 2'(push) - 2'(pop);
    fetch_fifo #(.PC_W(PC_W), .INSTR_W(INSTR_W)) fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .push_data(bus.imem_rdata),
        .push_pc  (issued_pc),
        .head_data(head_data),
        .head_pc  (head_pc),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = count_n < 2'd2 ? REQ : IDLE;
            REQ:     state_n = granted ? WAIT : REQ;
            WAIT:    state_n = !accept ? WAIT : count_n < 2'd2 ? REQ : IDLE;
            default: state_n = IDLE;
        endcase
    end
    // drop marks an in-flight response that belongs to the pre-redirect stream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            issued_pc <= '0;
            drop <= 1'b0;
        end else begin
            fetch_pc <= flush ? bus.pc_target : granted ? fetch_pc + PC_W'(1) : fetch_pc;
            issued_pc <= granted ? fetch_pc : issued_pc;
            drop <= flush ? granted || (state == WAIT && !bus.imem_rvalid) : accept ? 1'b0 : drop;
        end
    end
    always_comb begin
        bus.imem_req = state == REQ;
        bus.imem_addr = fetch_pc;
        bus.instr_valid = !empty;
        bus.instr = head_data;
        bus.instr_pc = head_pc;
        bus.op = head_data[INSTR_W-1 -: 4];
        bus.func3 = head_data[INSTR_W-5 -: 4];
    end
endmodule
